adc7928_spi_responder: RTL and testbench

Synthesizable AD7928-style SPI responder: the ADC end of the 16-bit control/data frame issued by the design's SPI master. It receives the control word on MOSI and returns `{1'b0, ADD[2:0], sample, zero pad}` on MISO, with the channel selected by the previous frame. Channel sample values come from a parallel input bus. It replaces behavioural ADC models in system benches and serves as an on-FPGA loopback target.

---
 rtl/adc7928_pkg.sv | 26 ++
 rtl/adc7928_spi_responder_sync.sv | 26 ++
 rtl/adc7928_spi_responder.sv | 163 ++++++++++++++++
 tb/tb_adc7928_spi_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc7928_pkg.sv
// AD7928-style SPI responder: shared constants.
// Control-word bit positions, frame length and FSM states.
package adc7928_pkg;

  localparam int FRAME_LEN  = 16;
  localparam int WRITE_BIT  = 15;
  localparam int SEQ_BIT    = 14;
  localparam int ADD_MSB    = 12;
  localparam int ADD_LSB    = 10;
  localparam int SHADOW_BIT = 7;
  localparam int CODING_BIT = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t SHIFT   = 2'd1;
  localparam state_t WAIT_CS = 2'd2;

  function automatic logic [2:0] seq_next(
    input logic [2:0] addr,
    input logic [2:0] last
  );
    return (addr == last) ? 3'd0 : addr + 3'd1;
  endfunction

endpackage

// File: rtl/adc7928_spi_responder_sync.sv
// Two-flop synchronizer for asynchronous SPI pins.
// Reset value is per-bit so idle levels are preserved.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage metastability filter
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc7928_spi_responder.sv
// AD7928-style SPI responder: ADC end of the 16-bit frame.
// Returns {0, ADD, sample, pad} and decodes the control word.
module adc7928_spi_responder
  import adc7928_pkg::*;
#(
  parameter int DOUT_WIDTH = 8,
  parameter int NUM_CH     = 8
) (
  input  logic                         CLK,
  input  logic                         rstn,
  input  logic                         sck,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic                         miso,
  input  logic [NUM_CH*DOUT_WIDTH-1:0] ch_data,
  output logic [2:0]                   ch_addr,
  output logic [15:0]                  ctrl_word,
  output logic                         ctrl_valid,
  output logic                         frame_err
);

  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

  logic [2:0] pins_s;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_d, cs_d;
  logic       sck_fall, cs_fall, cs_rise;

  state_t      state;
  logic [3:0]  bitcnt;
  logic [15:0] rx_shift, tx_shift;
  logic [15:0] rx_next, tx_word;
  logic        coding, seq_en;
  logic [2:0]  seq_last;

  logic [DOUT_WIDTH-1:0] sample, smp;
  logic [11:0]           data12;

  logic wr, seq, shadow;

  sync_2ff #(
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_sync (
    .CLK  (CLK),
    .rstn (rstn),
    .d    ({sck, cs_n, mosi}),
    .q    (pins_s)
  );

  assign {sck_s, cs_s, mosi_s} = pins_s;

  // Previous synchronized levels for edge detection
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      sck_d <= 1'b1;
      cs_d  <= 1'b1;
    end else begin
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_fall = sck_d & ~sck_s;
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;

  // Select current channel and format the 12-bit data field
  always_comb begin
    sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_addr == 3'(k))
        sample = ch_data[k*DOUT_WIDTH +: DOUT_WIDTH];
    end
    smp = sample;
    smp[DOUT_WIDTH-1] = sample[DOUT_WIDTH-1] ^ ~coding;
    data12 = 12'(smp) << (12 - DOUT_WIDTH);
  end

  assign tx_word = {1'b0, ch_addr, data12};
  assign rx_next = {rx_shift[14:0], mosi_s};
  assign wr      = rx_next[WRITE_BIT];
  assign seq     = rx_next[SEQ_BIT];
  assign shadow  = rx_next[SHADOW_BIT];

  // Frame FSM, shifter and control-word commit
  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      miso       <= 1'b0;
      bitcnt     <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      ch_addr    <= '0;
      ctrl_word  <= '0;
      ctrl_valid <= 1'b0;
      frame_err  <= 1'b0;
      coding     <= 1'b1;
      seq_en     <= 1'b0;
      seq_last   <= '0;
    end else begin
      ctrl_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            tx_shift <= tx_word;
            miso     <= tx_word[15];
            rx_shift <= '0;
            bitcnt   <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sck_fall && bitcnt == LAST) begin
            miso       <= 1'b0;
            state      <= WAIT_CS;
            ctrl_valid <= 1'b1;
            ctrl_word  <= rx_next;
            if (wr)
              coding <= rx_next[CODING_BIT];
            unique case (1'b1)
              (wr && !seq): begin
                seq_en  <= 1'b0;
                ch_addr <= rx_next[ADD_MSB:ADD_LSB];
              end
              (wr && seq && shadow): begin
                seq_en   <= 1'b1;
                seq_last <= rx_next[ADD_MSB:ADD_LSB];
                ch_addr  <= '0;
              end
              default: begin
                if (seq_en)
                  ch_addr <= seq_next(ch_addr, seq_last);
              end
            endcase
          end else if (cs_rise) begin
            frame_err <= 1'b1;
            miso      <= 1'b0;
            rx_shift  <= '0;
            state     <= IDLE;
          end else if (sck_fall) begin
            rx_shift <= rx_next;
            tx_shift <= {tx_shift[14:0], 1'b0};
            miso     <= tx_shift[14];
            bitcnt   <= bitcnt + 4'd1;
          end
        end
        WAIT_CS: begin
          miso <= 1'b0;
          if (cs_rise)
            state <= IDLE;
        end
        default: begin
          miso  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc7928_spi_responder.sv
// Bench for adc7928_spi_responder: directed frames plus random
// frames against a behavioural ADC model.
module tb_adc7928_spi_responder;

  logic        CLK = 1'b0;
  logic        rstn = 1'b0;
  logic        sck = 1'b1;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [63:0] ch_data = '0;
  logic [2:0]  ch_addr;
  logic [15:0] ctrl_word;
  logic        ctrl_valid;
  logic        frame_err;

  adc7928_spi_responder dut (
    .CLK        (CLK),
    .rstn       (rstn),
    .sck        (sck),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .ch_data    (ch_data),
    .ch_addr    (ch_addr),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .frame_err  (frame_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int cv_cnt = 0;
  int fe_cnt = 0;

  // model of the ADC's architectural state
  int          m_addr = 0;
  bit          m_coding = 1'b1;
  bit          m_seq_en = 1'b0;
  int          m_seq_last = 0;
  logic [15:0] m_cw = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (ctrl_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  // between frames the outputs must reflect the model exactly
  always @(negedge CLK) begin
    if (chk_en && rstn) begin
      chk("idle_addr", 32'(ch_addr), 32'(m_addr));
      chk("idle_cw", 32'(ctrl_word), 32'(m_cw));
      chk("idle_miso", 32'(miso), 32'd0);
      chk("idle_pulse", {30'd0, ctrl_valid, frame_err}, 32'd0);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  function automatic logic [15:0] exp_word();
    logic [7:0] s;
    s = ch_data[m_addr*8 +: 8];
    if (!m_coding) s[7] = ~s[7];
    return {1'b0, 3'(m_addr), s, 4'h0};
  endfunction

  function automatic void model_commit(input logic [15:0] w);
    m_cw = w;
    if (w[15]) m_coding = w[4];
    if (w[15] && !w[14]) begin
      m_seq_en = 1'b0;
      m_addr   = int'(w[12:10]);
    end else if (w[15] && w[14] && w[7]) begin
      m_seq_en   = 1'b1;
      m_seq_last = int'(w[12:10]);
      m_addr     = 0;
    end else if (m_seq_en) begin
      m_addr = (m_addr == m_seq_last) ? 0 : (m_addr + 1) % 8;
    end
  endfunction

  function automatic void model_reset();
    m_addr = 0; m_coding = 1'b1; m_seq_en = 1'b0;
    m_seq_last = 0; m_cw = '0;
  endfunction

  // master: nf sck falls, miso sampled just before each fall
  task automatic frame(input logic [15:0] w, input int nf,
                       input bit scramble, output logic [15:0] got);
    got = '0;
    cs_n = 1'b0;
    clks(6);
    if (scramble) ch_data = {$urandom, $urandom};
    for (int i = 0; i < nf; i++) begin
      mosi = w[15-i];
      clks(3);
      got[15-i] = miso;
      sck = 1'b0;
      clks(6);
      sck = 1'b1;
      clks(3);
    end
    clks(3);
    cs_n = 1'b1;
    clks(6);
  endtask

  task automatic run(input logic [15:0] w, input int nf,
                     input bit scramble, output logic [15:0] got);
    logic [15:0] ew;
    int cv0, fe0;
    ew  = exp_word();
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    chk_en = 1'b0;
    frame(w, nf, scramble, got);
    if (nf == 16) begin
      chk("miso_word", 32'(got), 32'(ew));
      chk("valid_cnt", cv_cnt - cv0, 1);
      chk("err_cnt", fe_cnt - fe0, 0);
      model_commit(w);
    end else begin
      chk("abort_valid", cv_cnt - cv0, 0);
      chk("abort_err", fe_cnt - fe0, 1);
    end
    chk_en = 1'b1;
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] w;
    int nf, r, fe0;

    // reset
    clks(30);
    chk("rst_miso", 32'(miso), 0);
    chk("rst_addr", 32'(ch_addr), 0);
    chk("rst_cw", 32'(ctrl_word), 0);
    chk("rst_pulse", {30'd0, ctrl_valid, frame_err}, 0);
    rstn = 1'b1;
    clks(5);
    chk_en = 1'b1;

    // select channel 3, then read it back
    ch_data[31:24] = 8'hA5;
    run(16'h8C10, 16, 1'b0, got);
    chk("f1_cw", 32'(ctrl_word), 32'h8C10);
    chk("f1_addr", 32'(ch_addr), 3);
    run(16'h0000, 16, 1'b0, got);
    chk("f2_miso", 32'(got), 32'h3A50);

    // twos-complement coding
    run(16'h8C00, 16, 1'b0, got);
    run(16'h0000, 16, 1'b0, got);
    chk("twos_miso", 32'(got), 32'h3250);

    // sequencer over channels 0..2
    ch_data[7:0]   = 8'h11;
    ch_data[15:8]  = 8'h22;
    ch_data[23:16] = 8'h33;
    run(16'hC890, 16, 1'b0, got);
    run(16'h0000, 16, 1'b0, got);
    chk("seq0", 32'(got), 32'h0110);
    run(16'h0000, 16, 1'b0, got);
    chk("seq1", 32'(got), 32'h1220);
    run(16'h0000, 16, 1'b0, got);
    chk("seq2", 32'(got), 32'h2330);
    run(16'h0000, 16, 1'b0, got);
    chk("seq_wrap", 32'(got), 32'h0110);

    // aborted frame leaves state alone
    run(16'h8C00, 10, 1'b0, got);
    chk("abort_addr", 32'(ch_addr), 1);
    run(16'h0000, 16, 1'b0, got);
    chk("post_abort", 32'(got), 32'h1220);

    // reset in the middle of a frame
    run(16'h8800, 16, 1'b0, got);
    chk_en = 1'b0;
    fe0 = fe_cnt;
    cs_n = 1'b0;
    clks(6);
    for (int i = 0; i < 7; i++) begin
      mosi = 1'($urandom);
      clks(3);
      sck = 1'b0;
      clks(6);
      sck = 1'b1;
      clks(3);
    end
    rstn = 1'b0;
    #1;
    chk("mrst_miso", 32'(miso), 0);
    chk("mrst_addr", 32'(ch_addr), 0);
    chk("mrst_cw", 32'(ctrl_word), 0);
    model_reset();
    clks(3);
    cs_n = 1'b1;
    clks(3);
    rstn = 1'b1;
    clks(6);
    chk("mrst_noerr", fe_cnt - fe0, 0);
    chk_en = 1'b1;
    ch_data[7:0] = 8'h9C;
    run(16'h0000, 16, 1'b0, got);
    chk("mrst_next", 32'(got), 32'h09C0);

    // random frames
    for (int n = 0; n < 40; n++) begin
      ch_data = {$urandom, $urandom};
      w = 16'($urandom);
      r = $urandom_range(0, 3);
      if (r == 1) begin
        w[15] = 1'b1; w[14] = 1'b1; w[7] = 1'b1;
      end else if (r == 2) begin
        w[15] = 1'b0;
      end else if (r == 3) begin
        w[15] = 1'b1; w[14] = 1'b0;
      end
      nf = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
      run(w, nf, 1'b1, got);
    end

    chk_en = 1'b0;
    clks(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
